// File: rtl/cache_wb_param.sv
// cache_wb_param: direct-mapped, write-back, write-allocate cache with
// saturating hit/miss counters.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   cpu_req_*          - CPU request (valid/ready), word address {tag,index,offset}
//   cpu_resp_*         - one-cycle completion pulse with read data and hit flag
//   mem_req_*          - word-serial memory request (valid/ready), we=1 for write-back
//   mem_resp_*         - refill read data return
//   hit_count/miss_count - saturating performance counters
module cache_wb_param #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              cpu_resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL_REQ, REFILL_WAIT, RESPOND} state_t;

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] k_q, k_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [LINES-1:0]    valid_q, dirty_q;
  logic                resp_valid_q, resp_hit_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WORDS];

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                hit, last_k, acc_wr, refill_wr;
  logic [DATA_W-1:0]   req_word;

  assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx   = addr_q[OFFSET_W +: INDEX_W];
  assign req_off   = addr_q[OFFSET_W-1:0];
  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_k    = (k_q == '1);
  assign req_word  = data_mem[{req_idx, req_off}];
  // CPU word access happens on a first-lookup hit or after the refill completes.
  assign acc_wr    = we_q && ((state_q == LOOKUP && hit) || state_q == RESPOND);
  assign refill_wr = (state_q == REFILL_WAIT) && mem_resp_valid;

  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_hit   = resp_hit_q;
  assign cpu_resp_rdata = resp_rdata_q;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;

  // Memory request is purely a function of state/k, so it stays stable
  // across ready stalls and drops the moment rst forces state to IDLE.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state_q)
      IDLE: if (cpu_req_valid) state_d = LOOKUP;
      LOOKUP: begin
        k_d = '0;
        if (hit)                                       state_d = IDLE;
        else if (valid_q[req_idx] && dirty_q[req_idx]) state_d = WB;
        else                                           state_d = REFILL_REQ;
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {tag_mem[req_idx], req_idx, k_q};
        mem_req_wdata = data_mem[{req_idx, k_q}];
        if (mem_req_ready) begin
          k_d = k_q + 1'b1;                 // wraps to 0 for the refill
          if (last_k) state_d = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_idx, k_q};
        if (mem_req_ready) state_d = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (mem_resp_valid) begin
          if (last_k) state_d = RESPOND;
          else begin
            k_d     = k_q + 1'b1;
            state_d = REFILL_REQ;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      if (state_q == IDLE && cpu_req_valid) begin
        we_q    <= cpu_req_we;
        addr_q  <= cpu_req_addr;
        wdata_q <= cpu_req_wdata;
      end
      if (state_q == LOOKUP) begin
        if (hit) begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= 1'b1;
          resp_rdata_q <= we_q ? wdata_q : req_word;
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
        end else begin
          // Line is about to be overwritten word by word; it is not usable
          // until the refill finishes.
          valid_q[req_idx] <= 1'b0;
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
      end
      if (refill_wr && last_k) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (state_q == RESPOND) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= we_q ? wdata_q : req_word;
      end
      if (acc_wr) dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset.
  always_ff @(posedge clk) begin
    if (acc_wr) data_mem[{req_idx, req_off}] <= wdata_q;
    if (refill_wr) begin
      data_mem[{req_idx, k_q}] <= mem_resp_rdata;
      if (last_k) tag_mem[req_idx] <= req_tag;
    end
  end
endmodule
